// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline constants, MD FSM states and register-match helpers
//   FWD_* : EXE operand select encodings
//   md_state_t : mult/div busy FSM encoding
//   reg_match / fwd_sel : producer-vs-consumer register compare helpers
package pipe_hazard_ctrl_pkg;
    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    function automatic logic reg_match(input logic we, input logic [4:0] dst,
                                       input logic [4:0] src, input logic use_src);
        return we & (dst != REG_ZERO) & (dst == src) & use_src;
    endfunction

    // Loads in MEM have no data yet, so only ALU results forward from MEM.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic m_we, input logic m_ld, input logic [4:0] m_dst,
                                           input logic w_we, input logic [4:0] w_dst);
        return reg_match(m_we & ~m_ld, m_dst, src, 1'b1) ? FWD_MEM :
               reg_match(w_we, w_dst, src, 1'b1) ? FWD_WB : FWD_REG;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_fsm.sv
// md_busy_fsm: mult/div occupancy tracker, busy for MD_LAT cycles after an accepted start
//   Clk, Reset (async, active-high), start (issue accepted this cycle), busy (unit occupied)
module md_busy_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic busy
);
    md_state_t  state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == MD_IDLE) begin
            state_nxt = start ? MD_BUSY : MD_IDLE;
            cnt_nxt   = start ? 8'(MD_LAT - 1) : cnt;
        end else begin
            state_nxt = (cnt == 8'd0) ? MD_IDLE : MD_BUSY;
            cnt_nxt   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
        end
    end

    assign busy = (state == MD_BUSY);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/mult-div hazard stall, flush and EXE forwarding control
//   in : Clk, Reset (async, active-high), ID sources/usage/branch/md flags, E/M/W dest ids and write flags
//   out: PC_Write_En, IR_Write_En, IR_Flush, ID_EXE_Flush, Fwd_A, Fwd_B, Md_Busy, Stall_Count
//   PIPE_HAZARD_FWD_EN: when defined, EXE forwarding is active; otherwise every RAW dependency stalls
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT  = 32,
    parameter int STALL_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [4:0]         D_Rs,
    input  logic [4:0]         D_Rt,
    input  logic               D_Use_Rs,
    input  logic               D_Use_Rt,
    input  logic               D_Is_Branch,
    input  logic               D_Branch_Taken,
    input  logic               D_Md_Start,
    input  logic               D_Md_Read,
    input  logic [4:0]         E_Dst_id,
    input  logic [4:0]         M_Dst_id,
    input  logic [4:0]         W_Dst_id,
    input  logic               E_Write_Reg_En,
    input  logic               M_Write_Reg_En,
    input  logic               W_Write_Reg_En,
    input  logic               E_Mem_to_Reg,
    input  logic               M_Mem_to_Reg,
    output logic               PC_Write_En,
    output logic               IR_Write_En,
    output logic               IR_Flush,
    output logic               ID_EXE_Flush,
    output logic [1:0]         Fwd_A,
    output logic [1:0]         Fwd_B,
    output logic               Md_Busy,
    output logic [STALL_W-1:0] Stall_Count
);
    logic hz_e, hz_m, data_stall, stall;

    assign hz_e = reg_match(E_Write_Reg_En, E_Dst_id, D_Rs, D_Use_Rs) |
                  reg_match(E_Write_Reg_En, E_Dst_id, D_Rt, D_Use_Rt);
    assign hz_m = reg_match(M_Write_Reg_En, M_Dst_id, D_Rs, D_Use_Rs) |
                  reg_match(M_Write_Reg_En, M_Dst_id, D_Rt, D_Use_Rt);

`ifdef PIPE_HAZARD_FWD_EN
    logic [4:0] e_rs, e_rt;

    // Branches resolve in ID, so they wait for E results and for loads still in MEM.
    assign data_stall = (hz_e & E_Mem_to_Reg) | (D_Is_Branch & (hz_e | (hz_m & M_Mem_to_Reg)));

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            e_rs <= REG_ZERO;
            e_rt <= REG_ZERO;
        end else begin
            e_rs <= (stall | ~D_Use_Rs) ? REG_ZERO : D_Rs;
            e_rt <= (stall | ~D_Use_Rt) ? REG_ZERO : D_Rt;
        end

    assign Fwd_A = fwd_sel(e_rs, M_Write_Reg_En, M_Mem_to_Reg, M_Dst_id, W_Write_Reg_En, W_Dst_id);
    assign Fwd_B = fwd_sel(e_rt, M_Write_Reg_En, M_Mem_to_Reg, M_Dst_id, W_Write_Reg_En, W_Dst_id);
`else
    logic hz_w, unused_nofwd;

    assign hz_w = reg_match(W_Write_Reg_En, W_Dst_id, D_Rs, D_Use_Rs) |
                  reg_match(W_Write_Reg_En, W_Dst_id, D_Rt, D_Use_Rt);
    assign data_stall   = hz_e | hz_m | hz_w;
    assign unused_nofwd = ^{E_Mem_to_Reg, M_Mem_to_Reg, D_Is_Branch};
    assign Fwd_A        = FWD_REG;
    assign Fwd_B        = FWD_REG;
`endif

    assign stall = data_stall | ((D_Md_Start | D_Md_Read) & Md_Busy);

    md_busy_fsm #(.MD_LAT(MD_LAT)) u_md (
        .Clk   (Clk),
        .Reset (Reset),
        .start (D_Md_Start & ~stall),
        .busy  (Md_Busy)
    );

    assign PC_Write_En  = ~Reset & ~stall;
    assign IR_Write_En  = ~Reset & ~stall;
    assign IR_Flush     = ~Reset & ~stall & D_Branch_Taken;
    assign ID_EXE_Flush = Reset | stall;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset)
            Stall_Count <= '0;
        else if (stall & ~&Stall_Count)
            Stall_Count <= Stall_Count + STALL_W'(1);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving a simple instruction pipeline into pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int MD_LAT  = 4;
    localparam int STALL_W = 16;
    localparam int CNT_MAX = (1 << STALL_W) - 1;

    typedef struct packed {
        logic [4:0] dst, rs, rt;
        logic we, ld, urs, urt, br, bt, mds, mdr;
    } ins_t;

    typedef struct packed {
        logic pc, ir, irf, idf;
        logic [1:0] fa, fb;
        logic busy;
        logic [15:0] cnt;
    } exp_t;

    localparam ins_t NOP = '0;

    logic Clk = 1'b0, Reset = 1'b1;
    logic [4:0] D_Rs = '0, D_Rt = '0, E_Dst_id = '0, M_Dst_id = '0, W_Dst_id = '0;
    logic D_Use_Rs = 0, D_Use_Rt = 0, D_Is_Branch = 0, D_Branch_Taken = 0, D_Md_Start = 0, D_Md_Read = 0;
    logic E_Write_Reg_En = 0, M_Write_Reg_En = 0, W_Write_Reg_En = 0, E_Mem_to_Reg = 0, M_Mem_to_Reg = 0;
    logic PC_Write_En, IR_Write_En, IR_Flush, ID_EXE_Flush, Md_Busy;
    logic [1:0] Fwd_A, Fwd_B;
    logic [STALL_W-1:0] Stall_Count;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .STALL_W(STALL_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_Use_Rs(D_Use_Rs), .D_Use_Rt(D_Use_Rt),
        .D_Is_Branch(D_Is_Branch), .D_Branch_Taken(D_Branch_Taken),
        .D_Md_Start(D_Md_Start), .D_Md_Read(D_Md_Read),
        .E_Dst_id(E_Dst_id), .M_Dst_id(M_Dst_id), .W_Dst_id(W_Dst_id),
        .E_Write_Reg_En(E_Write_Reg_En), .M_Write_Reg_En(M_Write_Reg_En), .W_Write_Reg_En(W_Write_Reg_En),
        .E_Mem_to_Reg(E_Mem_to_Reg), .M_Mem_to_Reg(M_Mem_to_Reg),
        .PC_Write_En(PC_Write_En), .IR_Write_En(IR_Write_En), .IR_Flush(IR_Flush),
        .ID_EXE_Flush(ID_EXE_Flush), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B),
        .Md_Busy(Md_Busy), .Stall_Count(Stall_Count)
    );

    always #5 Clk = ~Clk;

    int tests = 0, fails = 0;
    exp_t exp_q[$];
    exp_t mx;

    // Reference model state: cycle index, last busy cycle of the mult/div, stall total, EXE sources.
    int m_cyc = 0, m_md_until = -1, m_cnt = 0;
    logic [4:0] m_ers = '0, m_ert = '0;

    ins_t e_i = NOP, m_i = NOP, w_i = NOP;
    bit flush = 0;
    ins_t prog[$];

    function automatic bit hit(logic we, logic [4:0] dst, logic [4:0] src, logic u);
        return u && we && dst != 0 && dst == src;
    endfunction

    function automatic bit reads(ins_t p, ins_t id);
        return hit(p.we, p.dst, id.rs, id.urs) || hit(p.we, p.dst, id.rt, id.urt);
    endfunction

    function automatic logic [1:0] fwd(ins_t m, ins_t w, logic [4:0] src);
`ifdef PIPE_HAZARD_FWD_EN
        if (!m.ld && hit(m.we, m.dst, src, 1'b1)) return 2'b01;
        if (hit(w.we, w.dst, src, 1'b1)) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic void chk(string n, logic [15:0] a, logic [15:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    task automatic step(input logic rst, input ins_t id, input ins_t e, input ins_t m, input ins_t w,
                        output bit stall);
        exp_t x;
        bit busy, dep;
        @(posedge Clk);
        #1;
        Reset = rst;
        D_Rs = id.rs; D_Rt = id.rt; D_Use_Rs = id.urs; D_Use_Rt = id.urt;
        D_Is_Branch = id.br; D_Branch_Taken = id.bt; D_Md_Start = id.mds; D_Md_Read = id.mdr;
        E_Dst_id = e.dst; E_Write_Reg_En = e.we; E_Mem_to_Reg = e.ld;
        M_Dst_id = m.dst; M_Write_Reg_En = m.we; M_Mem_to_Reg = m.ld;
        W_Dst_id = w.dst; W_Write_Reg_En = w.we;
        busy = m_cyc <= m_md_until;
`ifdef PIPE_HAZARD_FWD_EN
        dep = (reads(e, id) && e.ld) || (id.br && (reads(e, id) || (reads(m, id) && m.ld)));
`else
        dep = reads(e, id) || reads(m, id) || reads(w, id);
`endif
        stall = !rst && (dep || ((id.mds || id.mdr) && busy));
        if (rst) begin
            x = '0;
            x.idf = 1'b1;
            m_md_until = -1;
            m_cnt = 0;
            m_ers = '0;
            m_ert = '0;
        end else begin
            x.pc = !stall;
            x.ir = !stall;
            x.irf = !stall && id.bt;
            x.idf = stall;
            x.fa = fwd(m, w, m_ers);
            x.fb = fwd(m, w, m_ert);
            x.busy = busy;
            x.cnt = (m_cnt > CNT_MAX) ? 16'(CNT_MAX) : 16'(m_cnt);
            if (stall) m_cnt++;
            m_ers = (stall || !id.urs) ? 5'd0 : id.rs;
            m_ert = (stall || !id.urt) ? 5'd0 : id.rt;
            if (!stall && id.mds) m_md_until = m_cyc + MD_LAT;
        end
        m_cyc++;
        exp_q.push_back(x);
    endtask

    task automatic run(input int drain);
        ins_t id;
        bit st;
        while (prog.size() != 0 || flush || drain > 0) begin
            id = (flush || prog.size() == 0) ? NOP : prog[0];
            if (prog.size() == 0 && !flush) drain--;
            step(1'b0, id, e_i, m_i, w_i, st);
            w_i = m_i;
            m_i = e_i;
            if (st) e_i = NOP;
            else begin
                if (!flush && prog.size() != 0) void'(prog.pop_front());
                e_i = id;
                flush = id.br && id.bt;
            end
        end
    endtask

    task automatic reset_pipe(input int n);
        bit st;
        for (int i = 0; i < n; i++) step(1'b1, NOP, NOP, NOP, NOP, st);
        e_i = NOP; m_i = NOP; w_i = NOP; flush = 0;
    endtask

    function automatic ins_t alu(int d, int s, int t);
        ins_t i = NOP;
        i.dst = 5'(d); i.rs = 5'(s); i.rt = 5'(t); i.we = 1; i.urs = 1; i.urt = 1;
        return i;
    endfunction

    function automatic ins_t lw(int d, int s);
        ins_t i = NOP;
        i.dst = 5'(d); i.rs = 5'(s); i.we = 1; i.ld = 1; i.urs = 1;
        return i;
    endfunction

    function automatic ins_t beq(int s, int t, bit tk);
        ins_t i = NOP;
        i.rs = 5'(s); i.rt = 5'(t); i.urs = 1; i.urt = 1; i.br = 1; i.bt = tk;
        return i;
    endfunction

    function automatic ins_t mult(int s, int t);
        ins_t i = NOP;
        i.rs = 5'(s); i.rt = 5'(t); i.urs = 1; i.urt = 1; i.mds = 1;
        return i;
    endfunction

    function automatic ins_t mflo(int d);
        ins_t i = NOP;
        i.dst = 5'(d); i.we = 1; i.mdr = 1;
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i.dst = 5'($urandom_range(0, 3));
        i.rs  = 5'($urandom_range(0, 3));
        i.rt  = 5'($urandom_range(0, 3));
        i.we  = 1'($urandom_range(0, 1));
        i.ld  = i.we & 1'($urandom_range(0, 1));
        i.urs = 1'($urandom_range(0, 1));
        i.urt = 1'($urandom_range(0, 1));
        i.br  = $urandom_range(0, 5) == 0;
        i.bt  = i.br & 1'($urandom_range(0, 1));
        i.mds = $urandom_range(0, 7) == 0;
        i.mdr = !i.mds && $urandom_range(0, 7) == 0;
        return i;
    endfunction

    initial forever begin
        @(negedge Clk);
        if (exp_q.size() != 0) begin
            mx = exp_q.pop_front();
            chk("pc_write_en", 16'(PC_Write_En), 16'(mx.pc));
            chk("ir_write_en", 16'(IR_Write_En), 16'(mx.ir));
            chk("ir_flush", 16'(IR_Flush), 16'(mx.irf));
            chk("id_exe_flush", 16'(ID_EXE_Flush), 16'(mx.idf));
            chk("fwd_a", 16'(Fwd_A), 16'(mx.fa));
            chk("fwd_b", 16'(Fwd_B), 16'(mx.fb));
            chk("md_busy", 16'(Md_Busy), 16'(mx.busy));
            chk("stall_count", 16'(Stall_Count), mx.cnt);
        end
    end

    initial begin
        bit st;
        reset_pipe(3);
        prog.push_back(lw(5, 1)); prog.push_back(alu(6, 5, 2));
        run(4);
        prog.push_back(alu(3, 1, 2)); prog.push_back(alu(7, 3, 1));
        run(4);
        prog.push_back(alu(4, 1, 2)); prog.push_back(beq(4, 0, 1)); prog.push_back(alu(9, 1, 1));
        run(4);
        prog.push_back(alu(0, 1, 2)); prog.push_back(beq(0, 0, 1));
        run(4);
        prog.push_back(lw(6, 1)); prog.push_back(beq(6, 0, 0));
        run(4);
        prog.push_back(mult(1, 2)); prog.push_back(mflo(8)); prog.push_back(alu(2, 8, 8));
        run(8);
        prog.push_back(mult(1, 2));
        run(1);
        reset_pipe(2);
        prog.push_back(mult(3, 4)); prog.push_back(mflo(1));
        run(MD_LAT + 2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pipe(1);
            else begin
                prog.push_back(rnd());
                run(0);
            end
        end
        reset_pipe(1);
        for (int i = 0; i < CNT_MAX + 60; i++) step(1'b0, alu(6, 5, 0), lw(5, 1), NOP, NOP, st);
        reset_pipe(1);
        @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
